// File: rtl/branch_predictor.sv
// Bimodal BHT of 2-bit saturating counters; optional gshare hashing when GSHARE_EN is defined.
// Latency: lookup -> registered prediction 1 cycle; 2^IDX_W-cycle table init after reset.
// Backpressure: none; one lookup and one update accepted every cycle once ready.
module branch_predictor #(
    parameter int IDX_W  = 10,
    parameter int PC_LSB = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ready,
    input  logic             lk_valid,
    input  logic [31:0]      lk_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int ENTRIES = 1 << IDX_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             ready_q, ready_d;
    logic             pred_valid_q, pred_valid_d;
    logic             pred_taken_q, pred_taken_d;
    logic [IDX_W-1:0] pred_idx_q, pred_idx_d;

    logic [1:0]       bht_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [1:0]       upd_cnt;
    logic [1:0]       upd_new;
    logic [1:0]       lk_cnt;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [1:0]       wr_val;

`ifdef GSHARE_EN
    logic [IDX_W-1:0] ghr_q, ghr_d;
`endif

    logic unused_pc_bits;
    assign unused_pc_bits = ^{lk_pc[31:PC_LSB+IDX_W], lk_pc[PC_LSB-1:0]};

    always_comb begin
        upd_cnt = bht_q[upd_idx];
        if (upd_taken) begin
            upd_new = (upd_cnt == 2'b11) ? 2'b11 : upd_cnt + 2'd1;
        end else begin
            upd_new = (upd_cnt == 2'b00) ? 2'b00 : upd_cnt - 2'd1;
        end

`ifdef GSHARE_EN
        lk_idx = lk_pc[PC_LSB+IDX_W-1:PC_LSB] ^ ghr_q;
`else
        lk_idx = lk_pc[PC_LSB+IDX_W-1:PC_LSB];
`endif

        // Write-first: a same-cycle update to the looked-up entry wins
        lk_cnt = (upd_valid && (upd_idx == lk_idx)) ? upd_new : bht_q[lk_idx];

        state_d      = state_q;
        ptr_d        = ptr_q;
        ready_d      = ready_q;
        pred_valid_d = 1'b0;
        pred_taken_d = pred_taken_q;
        pred_idx_d   = pred_idx_q;
        wr_en        = 1'b0;
        wr_idx       = upd_idx;
        wr_val       = upd_new;
`ifdef GSHARE_EN
        ghr_d        = ghr_q;
`endif

        case (state_q)
            ST_INIT: begin
                wr_en  = 1'b1;
                wr_idx = ptr_q;
                wr_val = 2'b01;
                ptr_d  = ptr_q + IDX_W'(1);
                if (ptr_q == {IDX_W{1'b1}}) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                wr_en        = upd_valid;
                pred_valid_d = lk_valid;
                if (lk_valid) begin
                    pred_taken_d = lk_cnt[1];
                    pred_idx_d   = lk_idx;
                end
`ifdef GSHARE_EN
                if (upd_valid) begin
                    ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
                end
`endif
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            ptr_q        <= '0;
            ready_q      <= 1'b0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_idx_q   <= '0;
`ifdef GSHARE_EN
            ghr_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            ready_q      <= ready_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_idx_q   <= pred_idx_d;
`ifdef GSHARE_EN
            ghr_q        <= ghr_d;
`endif
        end
    end

    // Table contents need no reset: INIT rewrites every entry
    always_ff @(posedge clk) begin
        if (wr_en) begin
            bht_q[wr_idx] <= wr_val;
        end
    end

    assign ready      = ready_q;
    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign pred_idx   = pred_idx_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: reset/INIT timing, counter saturation, forwarding, re-reset.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic        lk_valid;
    logic [31:0] lk_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [9:0]  pred_idx;
    logic        upd_valid;
    logic [9:0]  upd_idx;
    logic        upd_taken;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor #(.IDX_W(10), .PC_LSB(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready),
        .lk_valid   (lk_valid),
        .lk_pc      (lk_pc),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_idx   (pred_idx),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_taken  (upd_taken)
    );

    typedef struct {
        logic        lv;
        logic [31:0] pc;
        logic        uv;
        logic [9:0]  ui;
        logic        ut;
        logic        etk;
        logic [9:0]  eidx;
    } vec_t;

    typedef struct {
        logic       vld;
        logic       tk;
        logic [9:0] idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    logic       last_tk;
    logic [9:0] last_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic lv, input logic [31:0] pc, input logic uv,
                       input logic [9:0] ui, input logic ut, input logic etk,
                       input logic [9:0] eidx);
        vec_t v;
        v.lv = lv; v.pc = pc; v.uv = uv; v.ui = ui; v.ut = ut; v.etk = etk; v.eidx = eidx;
        vecs.push_back(v);
    endtask

    task automatic step(input string tag, input logic lv, input logic [31:0] pc,
                        input logic uv, input logic [9:0] ui, input logic ut,
                        input logic etk, input logic [9:0] eidx);
        exp_t e;
        lk_valid = lv; lk_pc = pc; upd_valid = uv; upd_idx = ui; upd_taken = ut;
        if (lv) begin
            last_tk  = etk;
            last_idx = eidx;
        end
        e.vld = lv; e.tk = last_tk; e.idx = last_idx;
        sbq.push_back(e);
        @(posedge clk); #1;
        lk_valid = 1'b0; upd_valid = 1'b0;
        e = sbq.pop_front();
        chk({tag, " pred_valid"}, 32'(pred_valid), 32'(e.vld));
        chk({tag, " pred_taken"}, 32'(pred_taken), 32'(e.tk));
        chk({tag, " pred_idx"},   32'(pred_idx),   32'(e.idx));
    endtask

    // Reset is applied with lookups and updates active to show they are ignored
    task automatic reset_pulse(input string tag);
        rst = 1'b1; lk_valid = 1'b1; lk_pc = 32'h100;
        upd_valid = 1'b1; upd_idx = 10'h040; upd_taken = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk({tag, " rst ready"},      32'(ready),      32'd0);
        chk({tag, " rst pred_valid"}, 32'(pred_valid), 32'd0);
        chk({tag, " rst pred_taken"}, 32'(pred_taken), 32'd0);
        chk({tag, " rst pred_idx"},   32'(pred_idx),   32'd0);
    endtask

    task automatic wait_init(input string tag);
        int   cycles = 0;
        logic seen_pv = 1'b0;
        while (!ready && cycles < 2000) begin
            @(posedge clk); #1;
            cycles++;
            if (pred_valid) seen_pv = 1'b1;
        end
        chk({tag, " init cycles"},     32'(cycles),  32'd1024);
        chk({tag, " init pred_valid"}, 32'(seen_pv), 32'd0);
        lk_valid = 1'b0; upd_valid = 1'b0;
        last_tk = 1'b0; last_idx = 10'h0;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 1024; i++) begin
            step(tag, 1'b1, 32'(i) << 2, 1'b0, 10'h0, 1'b0, 1'b0, 10'(i));
        end
    endtask

    initial begin
        rst = 1'b1; lk_valid = 1'b0; lk_pc = '0;
        upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0;
        last_tk = 1'b0; last_idx = '0;
        @(posedge clk); #1;

        reset_pulse("por");
        wait_init("por");
        sweep("post_init");

`ifndef GSHARE_EN
        add(1, 32'h100, 0, 10'h000, 0, 0, 10'h040);
        add(0, 32'h0,   1, 10'h040, 1, 0, 10'h000);
        add(1, 32'h100, 0, 10'h000, 0, 1, 10'h040);
        for (int i = 0; i < 3; i++) add(0, 32'h0, 1, 10'h040, 1, 0, 10'h0);
        add(0, 32'h0,   1, 10'h040, 0, 0, 10'h000);
        add(1, 32'h100, 0, 10'h000, 0, 1, 10'h040);
        add(0, 32'h0,   1, 10'h040, 0, 0, 10'h000);
        add(1, 32'h100, 0, 10'h000, 0, 0, 10'h040);
        for (int i = 0; i < 10; i++) add(0, 32'h0, 1, 10'h005, 0, 0, 10'h0);
        add(0, 32'h0,   1, 10'h005, 1, 0, 10'h000);
        add(1, 32'h14,  0, 10'h000, 0, 0, 10'h005);
        for (int i = 0; i < 10; i++) add(0, 32'h0, 1, 10'h005, 1, 0, 10'h0);
        add(0, 32'h0,   1, 10'h005, 0, 0, 10'h000);
        add(1, 32'h14,  0, 10'h000, 0, 1, 10'h005);
        add(1, 32'h100, 1, 10'h040, 1, 1, 10'h040);
        add(1, 32'h300, 1, 10'h0C1, 1, 0, 10'h0C0);
        add(1, 32'h304, 0, 10'h000, 0, 1, 10'h0C1);
        add(0, 32'h0,   1, 10'h0C2, 1, 0, 10'h000);
        add(1, 32'h308, 1, 10'h0C2, 0, 0, 10'h0C2);
        add(1, 32'hFFFF_F104, 0, 10'h000, 0, 0, 10'h041);
        add(1, 32'h103, 0, 10'h000, 0, 1, 10'h040);
        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].lv, vecs[i].pc, vecs[i].uv,
                 vecs[i].ui, vecs[i].ut, vecs[i].etk, vecs[i].eidx);
        end
`else
        step("ghr_t0", 1'b0, 32'h0, 1'b1, 10'h200, 1'b1, 1'b0, 10'h0);
        step("ghr_t1", 1'b0, 32'h0, 1'b1, 10'h200, 1'b1, 1'b0, 10'h0);
        step("ghr_n",  1'b0, 32'h0, 1'b1, 10'h200, 1'b0, 1'b0, 10'h0);
        step("ghr_lk", 1'b1, 32'h100, 1'b0, 10'h0, 1'b0, 1'b0, 10'h046);
`endif

        reset_pulse("run_rst");
        wait_init("run_rst");
        step("rerun_040", 1'b1, 32'h100, 1'b0, 10'h0, 1'b0, 1'b0, 10'h040);
        step("rerun_005", 1'b1, 32'h14,  1'b0, 10'h0, 1'b0, 1'b0, 10'h005);
        step("rerun_200", 1'b1, 32'h800, 1'b0, 10'h0, 1'b0, 1'b0, 10'h200);

        reset_pulse("mid_init_a");
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
        end
        reset_pulse("mid_init_b");
        wait_init("mid_init");
        sweep("post_reinit");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
